// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
// Radix-2 iterative multiply/divide engine that owns the architectural
// HI/LO registers. The pipeline issues one op with a start pulse and
// stalls while busy is high. done pulses for one cycle when an op completes.
//
// Build option: define MULDIV_MADD_EN to recognise MADD/MADDU/MSUB/MSUBU,
// which accumulate the product into {HI,LO}. Without it those codes are
// ignored and the accumulate adder is not built.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
`ifdef MULDIV_MADD_EN
    localparam logic [5:0] OP_MADD  = 6'b011100;
    localparam logic [5:0] OP_MADDU = 6'b011101;
    localparam logic [5:0] OP_MSUB  = 6'b011110;
    localparam logic [5:0] OP_MSUBU = 6'b011111;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    // Control and architectural state
    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Iteration datapath: r_upper is the partial product high half or the
    // partial remainder; r_lower holds the multiplier or the dividend that
    // turns into the quotient; r_opnd is the multiplicand or divisor.
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;   // negate product / quotient at FIX
    logic             r_neg_r;   // negate remainder at FIX
    logic             r_is_div;
`ifdef MULDIV_MADD_EN
    acc_t             r_acc;
    acc_t             w_acc;
`endif

    // Decode outputs
    logic             w_rec;
    logic             w_div;
    logic             w_sgn;
    logic             w_mthi;
    logic             w_mtlo;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_quo_s;
    logic [WIDTH-1:0] w_rem_s;
    logic             w_last;

    // Decode the function code into recognised-op class and signedness
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_rec  = 1'b0;
        w_div  = 1'b0;
        w_sgn  = 1'b0;
        w_mthi = 1'b0;
        w_mtlo = 1'b0;
`ifdef MULDIV_MADD_EN
        w_acc  = ACC_NONE;
`endif
        case (op)
            OP_MULT:  begin w_rec = 1'b1; w_sgn = 1'b1; end
            OP_MULTU: begin w_rec = 1'b1; end
            OP_DIV:   begin w_rec = 1'b1; w_div = 1'b1; w_sgn = 1'b1; end
            OP_DIVU:  begin w_rec = 1'b1; w_div = 1'b1; end
            OP_MTHI:  begin w_rec = 1'b1; w_mthi = 1'b1; end
            OP_MTLO:  begin w_rec = 1'b1; w_mtlo = 1'b1; end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin w_rec = 1'b1; w_sgn = 1'b1; w_acc = ACC_ADD; end
            OP_MADDU: begin w_rec = 1'b1; w_acc = ACC_ADD; end
            OP_MSUB:  begin w_rec = 1'b1; w_sgn = 1'b1; w_acc = ACC_SUB; end
            OP_MSUBU: begin w_rec = 1'b1; w_acc = ACC_SUB; end
`endif
            default:  ;
        endcase
    end

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
    assign w_a_neg = w_sgn & A[WIDTH-1];
    assign w_b_neg = w_sgn & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;

    // Shift-add step: conditional add into the high half, carry kept in bit WIDTH
    assign w_sum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : '0);

    // Restoring divide step: shift in the next dividend bit, trial-subtract.
    // The shifted remainder is below twice the divisor, so bit WIDTH of the
    // difference is set exactly when the subtraction goes negative.
    assign w_rem_sh = {r_upper, r_lower[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};

    // Sign fix-up applied once at the FIX edge
    assign w_prod   = {r_upper, r_lower};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo_s  = r_neg_q ? -r_lower : r_lower;
    assign w_rem_s  = r_neg_r ? -r_upper : r_upper;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM, iteration datapath and HI/LO update with registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_upper  <= '0;
            r_lower  <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
`ifdef MULDIV_MADD_EN
            r_acc    <= ACC_NONE;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_rec) begin
                        r_dbz <= 1'b0;
                        if (w_mthi) begin
                            r_hi   <= A;
                            r_done <= 1'b1;
                        end else if (w_mtlo) begin
                            r_lo   <= A;
                            r_done <= 1'b1;
                        end else if (w_div && (B == '0)) begin
                            r_dbz  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_upper  <= '0;
                            r_lower  <= w_a_mag;
                            r_opnd   <= w_b_mag;
                            r_cnt    <= '0;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_is_div <= w_div;
`ifdef MULDIV_MADD_EN
                            r_acc    <= w_acc;
`endif
                            r_busy   <= 1'b1;
                            r_state  <= w_div ? S_DIV : S_MUL;
                        end
                    end
                end

                S_MUL: begin
                    r_upper <= w_sum[WIDTH:1];
                    r_lower <= {w_sum[0], r_lower[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= S_FIX;
                end

                S_DIV: begin
                    if (w_diff[WIDTH]) begin
                        r_upper <= w_rem_sh[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], 1'b0};
                    end else begin
                        r_upper <= w_diff[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= S_FIX;
                end

                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quo_s;
                        r_hi <= w_rem_s;
                    end else begin
`ifdef MULDIV_MADD_EN
                        case (r_acc)
                            ACC_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod_s;
                            ACC_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - w_prod_s;
                            default: {r_hi, r_lo} <= w_prod_s;
                        endcase
`else
                        {r_hi, r_lo} <= w_prod_s;
`endif
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign HI          = r_hi;
    assign LO          = r_lo;

endmodule
